// File: rtl/decoder_acc_requant_26s_16s.sv
// Accumulates a frame of signed products plus bias, requantizes to OUT_WIDTH with saturation.
// Optional fused ReLU on the output is enabled by defining DECODER_ACC_RELU_EN.
module decoder_acc_requant_26s_16s #(
  parameter int PROD_WIDTH = 26,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int MAX_TERMS  = 256
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_overrun
);

  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [0:0]                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        first_q, first_d;
  logic [OUT_WIDTH-1:0]        out_q, out_d;
  logic                        err_q, err_d;

  logic                        accept;
  logic                        lastBeat;
  logic signed [ACC_WIDTH-1:0] biasExt;
  logic signed [ACC_WIDTH-1:0] prodExt;
  logic signed [ACC_WIDTH-1:0] baseVal;
  logic signed [ACC_WIDTH-1:0] sumVal;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]        satVal;
  logic [OUT_WIDTH-1:0]        resultVal;

  assign in_ready    = (state_q == S_ACC);
  assign out_valid   = (state_q == S_OUT);
  assign out_data    = out_q;
  assign err_overrun = err_q;
  assign accept      = in_valid && in_ready;
  assign lastBeat    = in_last || (cnt_q == CNT_W'(MAX_TERMS - 1));

  // The bias enters pre-scaled into the product Q-format on the first beat only.
  always_comb begin
    biasExt = ACC_WIDTH'($signed(bias));
    prodExt = ACC_WIDTH'($signed(in_data));
    baseVal = first_q ? (biasExt <<< FRAC_SHIFT) : acc_q;
    sumVal  = baseVal + prodExt;
    shifted = sumVal >>> FRAC_SHIFT;
  end

  always_comb begin
    satVal = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      satVal = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      satVal = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
`ifdef DECODER_ACC_RELU_EN
    resultVal = satVal[OUT_WIDTH-1] ? '0 : satVal;
`else
    resultVal = satVal;
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          acc_d   = sumVal;
          cnt_d   = cnt_q + CNT_W'(1);
          first_d = 1'b0;
          if (lastBeat) begin
            out_d   = resultVal;
            state_d = S_OUT;
            // Hitting the term limit without in_last closes the frame and flags it.
            if (!in_last) begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_ACC;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_decoder_acc_requant_26s_16s.sv
// Scoreboard bench for decoder_acc_requant_26s_16s; MAX_TERMS is reduced to 4 so overrun is reachable.
module tb_decoder_acc_requant_26s_16s;

  logic               ap_clk;
  logic               ap_rst;
  logic signed [25:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic signed [15:0] bias;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               err_overrun;

  int compareCount = 0;
  int errorCount   = 0;
  logic [15:0] sbQ[$];
  longint prodQ[$];

  decoder_acc_requant_26s_16s #(
    .MAX_TERMS(4)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_overrun(err_overrun)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    compareCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference requantizer: floor shift, saturate, optional ReLU.
  function automatic logic [15:0] expectedOf(input longint acc);
    longint r;
    r = acc >>> 10;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef DECODER_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge ap_clk) begin
    #2;
    if (out_valid && out_ready) begin
      checkOutput("no_in_ready_in_out", longint'(in_ready), 0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out", longint'(out_data), -1);
      end else begin
        checkOutput("out_data", longint'(out_data), longint'(sbQ.pop_front()));
      end
    end
  end

  task automatic sendBeat(input longint d, input bit last, input logic [15:0] b);
    int n;
    in_data  = d[25:0];
    in_last  = last;
    bias     = b;
    in_valid = 1'b1;
    n = 0;
    #2;
    while (!in_ready && n < 100) begin
      @(negedge ap_clk);
      #2;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drives prodQ as one frame; bias is only meaningful on the first beat, so later beats carry junk.
  task automatic applyStimulus(input logic [15:0] b, input bit lastOnFinal);
    longint acc;
    int n;
    acc = longint'($signed(b)) <<< 10;
    n = prodQ.size();
    for (int i = 0; i < n; i++) begin
      acc += prodQ[i];
      if (i == n - 1) sbQ.push_back(expectedOf(acc));
      sendBeat(prodQ[i], lastOnFinal && (i == n - 1), (i == 0) ? b : 16'h5A5A);
    end
    prodQ.delete();
    #2;
    checkOutput("latency_out_valid", longint'(out_valid), 1);
    checkOutput("latency_in_ready", longint'(in_ready), 0);
    @(negedge ap_clk);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 50) begin
      @(negedge ap_clk);
      #3;
      n++;
    end
    if (sbQ.size() != 0) checkOutput("drain_timeout", sbQ.size(), 0);
    @(negedge ap_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    ap_rst    = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    #2;
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_data", longint'(out_data), 0);
    checkOutput("rst_err", longint'(err_overrun), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    $display("[TB] bias plus two products");
    prodQ = '{1024, 2048};
    applyStimulus(16'h0100, 1'b1);
    waitDrain();

    $display("[TB] positive and negative saturation");
    prodQ = '{30000000, 30000000};
    applyStimulus(16'h0000, 1'b1);
    waitDrain();
    prodQ = '{-30000000, -30000000};
    applyStimulus(16'h0000, 1'b1);
    waitDrain();

    $display("[TB] negative bias and floor rounding");
    prodQ = '{-2048};
    applyStimulus(16'hFFFB, 1'b1);
    waitDrain();
    prodQ = '{-1};
    applyStimulus(16'h0000, 1'b1);
    waitDrain();
    prodQ = '{1000, 2000, -500};
    applyStimulus(16'h0002, 1'b1);
    waitDrain();
    checkOutput("err_clear_3beats", longint'(err_overrun), 0);

    $display("[TB] output backpressure");
    out_ready = 1'b0;
    prodQ = '{2048};
    applyStimulus(16'h0010, 1'b1);
    in_data  = 26'sd1024;
    in_last  = 1'b1;
    bias     = 16'h0000;
    in_valid = 1'b1;
    sbQ.push_back(16'h0001);
    for (int i = 0; i < 5; i++) begin
      #2;
      checkOutput("hold_out_valid", longint'(out_valid), 1);
      checkOutput("hold_out_data", longint'(out_data), 16'h0012);
      checkOutput("hold_in_ready", longint'(in_ready), 0);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    n = 0;
    #2;
    while (!in_ready && n < 20) begin
      @(negedge ap_clk);
      #2;
      n++;
    end
    if (!in_ready) checkOutput("release_timeout", 0, 1);
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDrain();

    $display("[TB] overrun at term limit");
    prodQ = '{1024, 1024, 1024, 1024};
    applyStimulus(16'h0000, 1'b0);
    waitDrain();
    checkOutput("err_set", longint'(err_overrun), 1);
    prodQ = '{-1};
    applyStimulus(16'h0000, 1'b1);
    waitDrain();
    checkOutput("err_sticky", longint'(err_overrun), 1);

    $display("[TB] reset mid-frame");
    sendBeat(1024, 1'b0, 16'h0000);
    sendBeat(1024, 1'b0, 16'h0000);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #2;
    checkOutput("midrst_err", longint'(err_overrun), 0);
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_in_ready", longint'(in_ready), 1);
    @(negedge ap_clk);
    prodQ = '{1024};
    applyStimulus(16'h0000, 1'b1);
    waitDrain();
    checkOutput("post_rst_err", longint'(err_overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
